// File: rtl/flight_cntrl.sv
// flight_cntrl: quadcopter attitude PD controller and motor mixer.
// Saturated P/D terms per axis are mixed into four registered ESC speeds.
module flight_cntrl #(
    parameter int          D_QUEUE_DEPTH = 12,
    parameter logic [12:0] MIN_RUN_SPEED = 13'h2A5,
    parameter logic [10:0] CAL_SPEED     = 11'h1B0,
    parameter int          D_COEFF       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        inertial_cal,
    input  logic [15:0] d_ptch,
    input  logic [15:0] d_roll,
    input  logic [15:0] d_yaw,
    input  logic [15:0] ptch,
    input  logic [15:0] roll,
    input  logic [15:0] yaw,
    input  logic [8:0]  thrst,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd
);

    localparam int NAX = 3;
    localparam logic signed [9:0] D_MUL = 10'(D_COEFF);

    function automatic logic signed [9:0] sat10(input logic signed [16:0] v);
        if (v > 17'sd511)
            return 10'sh1FF;
        else if (v < -17'sd512)
            return 10'sh200;
        return v[9:0];
    endfunction

    function automatic logic signed [6:0] sat7(input logic signed [10:0] v);
        if (v > 11'sd63)
            return 7'sh3F;
        else if (v < -11'sd64)
            return 7'sh40;
        return v[6:0];
    endfunction

    function automatic logic [10:0] sat11(input logic signed [12:0] v);
        if (v[12])
            return 11'h000;
        else if (v[11])
            return 11'h7FF;
        return v[10:0];
    endfunction

    function automatic logic signed [12:0] ext13(input logic signed [9:0] v);
        return {{3{v[9]}}, v};
    endfunction

    // axis index: 0 = pitch, 1 = roll, 2 = yaw
    logic [15:0] meas [NAX];
    logic [15:0] des  [NAX];

    assign meas[0] = ptch;
    assign meas[1] = roll;
    assign meas[2] = yaw;
    assign des[0]  = d_ptch;
    assign des[1]  = d_roll;
    assign des[2]  = d_yaw;

    logic signed [16:0] err   [NAX];
    logic signed [9:0]  e_sat [NAX];
    logic signed [9:0]  p_trm [NAX];
    logic signed [10:0] diff  [NAX];
    logic signed [6:0]  d_sat [NAX];
    logic signed [9:0]  d_trm [NAX];
    logic signed [9:0]  hist  [NAX][D_QUEUE_DEPTH];

    always_comb begin
        for (int a = 0; a < NAX; a++) begin
            err[a]   = $signed({meas[a][15], meas[a]})
                     - $signed({des[a][15], des[a]});
            e_sat[a] = sat10(err[a]);
            p_trm[a] = (e_sat[a] >>> 1)
                     + ((a == 2) ? 10'sd0 : (e_sat[a] >>> 3));
            // oldest entry is read before this edge's push
            diff[a]  = $signed({e_sat[a][9], e_sat[a]})
                     - $signed({hist[a][D_QUEUE_DEPTH-1][9],
                                hist[a][D_QUEUE_DEPTH-1]});
            d_sat[a] = sat7(diff[a]);
            d_trm[a] = $signed({{3{d_sat[a][6]}}, d_sat[a]}) * D_MUL;
        end
    end

    logic signed [12:0] base;
    logic signed [12:0] pc;
    logic signed [12:0] rc;
    logic signed [12:0] yc;
    logic signed [12:0] frnt_sum;
    logic signed [12:0] bck_sum;
    logic signed [12:0] lft_sum;
    logic signed [12:0] rght_sum;

    always_comb begin
        base     = $signed(MIN_RUN_SPEED + {4'b0, thrst});
        pc       = ext13(p_trm[0]) + ext13(d_trm[0]);
        rc       = ext13(p_trm[1]) + ext13(d_trm[1]);
        yc       = ext13(p_trm[2]) + ext13(d_trm[2]);
        frnt_sum = base - pc - yc;
        bck_sum  = base + pc - yc;
        lft_sum  = base - rc + yc;
        rght_sum = base + rc + yc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frnt_spd <= '0;
            bck_spd  <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            for (int a = 0; a < NAX; a++)
                for (int i = 0; i < D_QUEUE_DEPTH; i++)
                    hist[a][i] <= '0;
        end else begin
            if (inertial_cal) begin
                frnt_spd <= CAL_SPEED;
                bck_spd  <= CAL_SPEED;
                lft_spd  <= CAL_SPEED;
                rght_spd <= CAL_SPEED;
            end else begin
                frnt_spd <= sat11(frnt_sum);
                bck_spd  <= sat11(bck_sum);
                lft_spd  <= sat11(lft_sum);
                rght_spd <= sat11(rght_sum);
            end
            if (vld) begin
                for (int a = 0; a < NAX; a++) begin
                    hist[a][0] <= e_sat[a];
                    for (int i = 1; i < D_QUEUE_DEPTH; i++)
                        hist[a][i] <= hist[a][i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_flight_cntrl.sv
// tb_flight_cntrl: randomized + directed scoreboard bench for flight_cntrl.
// A driver pushes model results; a monitor pops and compares each cycle.
module tb_flight_cntrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        inertial_cal;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [15:0] ptch, roll, yaw;
    logic [8:0]  thrst;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;

    flight_cntrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .inertial_cal (inertial_cal),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .ptch         (ptch),
        .roll         (roll),
        .yaw          (yaw),
        .thrst        (thrst),
        .frnt_spd     (frnt_spd),
        .bck_spd      (bck_spd),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int b;
        int l;
        int r;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // stimulus angles: measured (ax) and desired (dx), axis 0/1/2 = p/r/y
    int ax[3];
    int dx[3];
    int mhist[3][$];

    function automatic int clamp(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void clear_model();
        for (int a = 0; a < 3; a++) begin
            mhist[a].delete();
            for (int i = 0; i < 12; i++) mhist[a].push_back(0);
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit v, input bit cal,
                        input int thr, input int kf, input int kb,
                        input int kl, input int kr);
        exp_t e;
        int es, p, d, t;
        int corr[3];
        @(negedge clk);
        rst_n        = rn;
        vld          = v;
        inertial_cal = cal;
        thrst        = 9'(thr);
        ptch   = 16'(ax[0]);
        roll   = 16'(ax[1]);
        yaw    = 16'(ax[2]);
        d_ptch = 16'(dx[0]);
        d_roll = 16'(dx[1]);
        d_yaw  = 16'(dx[2]);
        if (!rn) begin
            e.f = 0; e.b = 0; e.l = 0; e.r = 0;
            clear_model();
        end else begin
            for (int a = 0; a < 3; a++) begin
                es = clamp(ax[a] - dx[a], -512, 511);
                p  = (a == 2) ? (es >>> 1) : (es >>> 1) + (es >>> 3);
                d  = clamp(es - mhist[a][0], -64, 63) * 7;
                corr[a] = p + d;
                if (v) begin
                    void'(mhist[a].pop_front());
                    mhist[a].push_back(es);
                end
            end
            t = 677 + thr;
            if (cal) begin
                e.f = 432; e.b = 432; e.l = 432; e.r = 432;
            end else begin
                e.f = clamp(t - corr[0] - corr[2], 0, 2047);
                e.b = clamp(t + corr[0] - corr[2], 0, 2047);
                e.l = clamp(t - corr[1] + corr[2], 0, 2047);
                e.r = clamp(t + corr[1] + corr[2], 0, 2047);
            end
        end
        if (kf >= 0) e.f = kf;
        if (kb >= 0) e.b = kb;
        if (kl >= 0) e.l = kl;
        if (kr >= 0) e.r = kr;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_angles();
        for (int a = 0; a < 3; a++) begin
            ax[a] = 0;
            dx[a] = 0;
        end
    endtask

    function automatic int rand_angle();
        if ($urandom_range(0, 3) == 0)
            return int'($signed(16'($urandom)));
        return int'($urandom_range(0, 1400)) - 700;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("frnt_spd", int'(frnt_spd), e.f);
                check("bck_spd",  int'(bck_spd),  e.b);
                check("lft_spd",  int'(lft_spd),  e.l);
                check("rght_spd", int'(rght_spd), e.r);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        vld = 1'b0;
        inertial_cal = 1'b0;
        thrst = '0;
        zero_angles();
        ptch = '0; roll = '0; yaw = '0;
        d_ptch = '0; d_roll = '0; d_yaw = '0;
        clear_model();

        do_reset();
        step(1'b1, 1'b0, 1'b0, 0, 677, 677, 677, 677);

        for (int a = 0; a < 3; a++) begin
            ax[a] = rand_angle();
            dx[a] = rand_angle();
        end
        step(1'b1, 1'b0, 1'b1, 200, 432, 432, 432, 432);

        for (int a = 0; a < 3; a++) begin
            ax[a] = rand_angle();
            dx[a] = ax[a];
        end
        step(1'b1, 1'b1, 1'b0, 100, 777, 777, 777, 777);

        do_reset();
        zero_angles();
        ax[0] = 100;
        step(1'b1, 1'b1, 1'b0, 0, 174, 1180, 677, 677);
        repeat (11) step(1'b1, 1'b1, 1'b0, 0, -1, -1, -1, -1);
        step(1'b1, 1'b1, 1'b0, 0, 615, 739, 677, 677);

        do_reset();
        zero_angles();
        ax[1] = 1000;
        ax[2] = 1000;
        step(1'b1, 1'b1, 1'b0, 511, -1, -1, -1, 2047);

        do_reset();
        zero_angles();
        ax[0] = 1000;
        ax[2] = 1000;
        step(1'b1, 1'b1, 1'b0, 511, 0, -1, -1, -1);

        do_reset();
        zero_angles();
        ax[0] = 100;
        repeat (5) step(1'b1, 1'b0, 1'b0, 0, 174, 1180, 677, 677);
        repeat (12) step(1'b1, 1'b1, 1'b0, 0, 174, 1180, 677, 677);
        step(1'b1, 1'b0, 1'b0, 0, 615, 739, 677, 677);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int a = 0; a < 3; a++) begin
                    ax[a] = rand_angle();
                    dx[a] = rand_angle();
                end
            end else begin
                for (int a = 0; a < 3; a++)
                    ax[a] = clamp(ax[a] + int'($urandom_range(0, 80)) - 40,
                                  -32768, 32767);
            end
            step(($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 511)),
                 -1, -1, -1, -1);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
